// File: rtl/cpu_clk_pkg.sv
// Shared definitions for the CPU clock-enable sequencer: mode encoding and the
// prescaler terminal-count clamp.
package cpu_clk_pkg;

    typedef logic [1:0] mode_t;

    localparam mode_t MODE_PAUSE = 2'd0;
    localparam mode_t MODE_RUN   = 2'd1;
    localparam mode_t MODE_STEP  = 2'd2;
    localparam mode_t MODE_HALT  = 2'd3;

    // Terminal count 2**min(sel, cnt_w) - 1; callers truncate to their counter width.
    function automatic logic [31:0] clamp_lim(input logic [31:0] sel, input int unsigned cnt_w);
        logic [31:0] e;
        e = (sel < cnt_w) ? sel : cnt_w;
        return (32'd1 << e) - 32'd1;
    endfunction

endpackage

// File: rtl/step_debounce.sv
// Level filter for the synchronized step button: dout takes a new value only after
// din has held that value for DEB_CYCLES consecutive cycles.
module step_debounce #(
    parameter int DEB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);
    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt  <= '0;
            dout <= 1'b0;
        end else if (din == dout) begin
            cnt <= '0;
        end else if (cnt == CW'(DEB_CYCLES - 1)) begin
            dout <= din;
            cnt  <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/cpu_clk_ctrl.sv
// CPU clock-enable sequencer: programmable prescaler with run, single-step and sticky halt.
// Build option STEP_DEBOUNCE_EN inserts step_debounce on the synchronized step button.
module cpu_clk_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int CNT_W      = 22,
    parameter int SEL_W      = 5,
    parameter int TCNT_W     = 16,
    parameter int DEB_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run_req,
    input  logic              step_btn,
    input  logic              halt_req,
    input  logic [SEL_W-1:0]  div_sel,
    output logic              cpu_ce,
    output logic [1:0]        mode,
    output logic [TCNT_W-1:0] tick_cnt
);
    mode_t            state, state_nx;
    logic [CNT_W-1:0] cnt, lim;
    logic             s1, s2, s3;
    logic             step_lvl, step_edge;
    logic             lim_hit, ce_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            {s1, s2, s3} <= '0;
        end else begin
            s1 <= step_btn;
            s2 <= s1;
            s3 <= step_lvl;
        end
    end

`ifdef STEP_DEBOUNCE_EN
    step_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_debounce (
        .clk  (clk),
        .rst  (rst),
        .din  (s2),
        .dout (step_lvl)
    );
`else
    // DEB_CYCLES only matters when the filter is built in.
    logic unused_deb;
    assign unused_deb = ^DEB_CYCLES;
    assign step_lvl   = s2;
`endif

    assign step_edge = step_lvl & ~s3;

    assign lim     = CNT_W'(clamp_lim(32'(div_sel), CNT_W));
    assign lim_hit = (cnt == lim);

    always_ff @(posedge clk) begin
        if (rst) state <= MODE_PAUSE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            MODE_PAUSE: begin
                if (halt_req)       state_nx = MODE_HALT;
                else if (run_req)   state_nx = MODE_RUN;
                else if (step_edge) state_nx = MODE_STEP;
            end
            MODE_RUN: begin
                if (halt_req)       state_nx = MODE_HALT;
                else if (!run_req)  state_nx = MODE_PAUSE;
            end
            MODE_STEP:              state_nx = halt_req ? MODE_HALT : MODE_PAUSE;
            default:                state_nx = MODE_HALT;
        endcase
    end

    // A step edge seen in RUN or STEP never reaches PAUSE, so it is simply dropped.
    always_comb begin
        ce_set = 1'b0;
        unique case (state)
            MODE_PAUSE: ce_set = (state_nx == MODE_STEP);
            MODE_RUN:   ce_set = lim_hit & run_req & ~halt_req;
            default:    ce_set = 1'b0;
        endcase
    end

    assign mode = state;

    // Count only while staying in RUN; an over-range count after a div_sel change
    // clears without producing a pulse because ce_set needs an exact match.
    always_ff @(posedge clk) begin
        if (rst)                                          cnt <= '0;
        else if (state != MODE_RUN || state_nx != MODE_RUN) cnt <= '0;
        else if (cnt >= lim)                              cnt <= '0;
        else                                              cnt <= cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_ce   <= 1'b0;
            tick_cnt <= '0;
        end else begin
            cpu_ce <= ce_set;
            if (ce_set) tick_cnt <= tick_cnt + TCNT_W'(1);
        end
    end

    a_ce_mode: assert property (@(posedge clk) disable iff (rst)
        cpu_ce |-> (mode == MODE_RUN || mode == MODE_STEP));
    a_step_1cyc: assert property (@(posedge clk) disable iff (rst)
        (mode == MODE_STEP) |=> (mode != MODE_STEP));

endmodule

// File: tb/tb_cpu_clk_ctrl.sv
// Bench for cpu_clk_ctrl: vector table, directed multi-cycle sequences and a random
// run against a behavioural model built on run-age arithmetic.
module tb_cpu_clk_ctrl;
    localparam int CNT_W  = 22;
    localparam int SEL_W  = 5;
    localparam int TCNT_W = 16;
    localparam int DEB    = 8;
`ifdef STEP_DEBOUNCE_EN
    localparam int LAT = 3 + DEB;
`else
    localparam int LAT = 3;
`endif

    logic              clk = 1'b0;
    logic              rst, run_req, step_btn, halt_req;
    logic [SEL_W-1:0]  div_sel;
    logic              cpu_ce;
    logic [1:0]        mode;
    logic [TCNT_W-1:0] tick_cnt;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    cpu_clk_ctrl #(.CNT_W(CNT_W), .SEL_W(SEL_W), .TCNT_W(TCNT_W), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst(rst), .run_req(run_req), .step_btn(step_btn), .halt_req(halt_req),
        .div_sel(div_sel), .cpu_ce(cpu_ce), .mode(mode), .tick_cnt(tick_cnt)
    );

    typedef struct {
        bit       rst, run, halt;
        bit [4:0] div;
        bit       ce;
        bit [1:0] mode;
        int       tick;
    } vec_t;

    vec_t tbl[18];

    function automatic vec_t mk(bit r, bit ru, bit h, bit [4:0] d, bit c, bit [1:0] m, int t);
        vec_t v;
        v.rst = r; v.run = ru; v.halt = h; v.div = d; v.ce = c; v.mode = m; v.tick = t;
        return v;
    endfunction

    task automatic step1();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string nm, longint act, longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        int pulses, last, bad_gap, first, t0, idx;
        bit found, nonhalt;
        int m_mode, m_tick;
        longint m_age, per;
        bit m_ce, se;
        bit bq[4];

        rst = 1; run_req = 0; step_btn = 0; halt_req = 0; div_sel = '0;

        // reset and idle
        step1(); step1();
        chk("rst_ce", cpu_ce, 0);
        chk("rst_mode", mode, 0);
        chk("rst_tick", tick_cnt, 0);
        rst = 0;
        pulses = 0;
        repeat (50) begin step1(); pulses += int'(cpu_ce); end
        chk("idle_pulses", pulses, 0);
        chk("idle_mode", mode, 0);

        // vector table: {rst, run, halt, div} -> {ce, mode, tick} after the edge
        tbl[0]  = mk(1, 0, 0, 0, 0, 0, 0);
        tbl[1]  = mk(1, 0, 0, 0, 0, 0, 0);
        tbl[2]  = mk(0, 1, 0, 1, 0, 1, 0);
        tbl[3]  = mk(0, 1, 0, 1, 0, 1, 0);
        tbl[4]  = mk(0, 1, 0, 1, 1, 1, 1);
        tbl[5]  = mk(0, 1, 0, 1, 0, 1, 1);
        tbl[6]  = mk(0, 1, 0, 1, 1, 1, 2);
        tbl[7]  = mk(0, 0, 0, 1, 0, 0, 2);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 2);
        tbl[9]  = mk(0, 1, 0, 0, 0, 1, 2);
        tbl[10] = mk(0, 1, 0, 0, 1, 1, 3);
        tbl[11] = mk(0, 1, 0, 0, 1, 1, 4);
        tbl[12] = mk(0, 1, 1, 0, 0, 3, 4);
        tbl[13] = mk(0, 1, 0, 0, 0, 3, 4);
        tbl[14] = mk(0, 0, 1, 0, 0, 3, 4);
        tbl[15] = mk(1, 0, 0, 0, 0, 0, 0);
        tbl[16] = mk(0, 1, 1, 0, 0, 3, 0);
        tbl[17] = mk(1, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 18; i++) begin
            rst = tbl[i].rst; run_req = tbl[i].run; halt_req = tbl[i].halt; div_sel = tbl[i].div;
            step1();
            chk($sformatf("tbl%0d_ce", i), cpu_ce, tbl[i].ce);
            chk($sformatf("tbl%0d_mode", i), mode, tbl[i].mode);
            chk($sformatf("tbl%0d_tick", i), tick_cnt, tbl[i].tick);
        end
        rst = 0; run_req = 0; halt_req = 0;

        // RUN with div_sel=2: period 4
        run_req = 1; div_sel = 5'd2;
        last = -1; bad_gap = 0;
        for (int i = 0; i < 40; i++) begin
            step1();
            if (cpu_ce) begin
                if (last >= 0 && i - last != 4) bad_gap++;
                last = i;
            end
        end
        chk("div2_gaps", bad_gap, 0);
        chk("div2_tick_in_9_11", (tick_cnt >= 9 && tick_cnt <= 11), 1);

        // div_sel=0: every cycle, then div_sel=3 without a glitch pulse
        div_sel = 5'd0;
        step1();
        pulses = 0;
        repeat (10) begin step1(); pulses += int'(cpu_ce); end
        chk("div0_every_cycle", pulses, 10);
        div_sel = 5'd3;
        pulses = 0; first = -1; last = -1; bad_gap = 0;
        for (int i = 0; i < 40; i++) begin
            step1();
            if (cpu_ce) begin
                if (first < 0) first = i;
                if (last >= 0 && i - last != 8) bad_gap++;
                last = i;
                pulses++;
            end
        end
        chk("div3_pulses", pulses, 5);
        chk("div3_first", first, 7);
        chk("div3_gaps", bad_gap, 0);
        run_req = 0;
        step1();
        chk("drop_run_mode", mode, 0);
        chk("drop_run_ce", cpu_ce, 0);
        pulses = 0;
        repeat (20) begin step1(); pulses += int'(cpu_ce); end
        chk("paused_pulses", pulses, 0);

        // single-step: one pulse per press, fixed latency
        t0 = int'(tick_cnt);
        step_btn = 1; pulses = 0; idx = -1;
        for (int i = 0; i < 20; i++) begin
            step1();
            if (cpu_ce) begin
                pulses++; idx = i;
                chk("step_mode", mode, 2);
            end
        end
        chk("step1_pulses", pulses, 1);
        chk("step1_latency", idx, LAT - 1);
        chk("step1_tick", tick_cnt, (t0 + 1) % 65536);
        step_btn = 0;
        repeat (20) step1();
        step_btn = 1; pulses = 0;
        repeat (20) begin step1(); pulses += int'(cpu_ce); end
        chk("step2_pulses", pulses, 1);
        chk("step2_tick", tick_cnt, (t0 + 2) % 65536);
        step_btn = 0;
        repeat (20) step1();
        chk("step_back_pause", mode, 0);

`ifdef STEP_DEBOUNCE_EN
        step_btn = 1; repeat (5) step1();
        step_btn = 0; pulses = 0;
        repeat (25) begin step1(); pulses += int'(cpu_ce); end
        chk("glitch5_pulses", pulses, 0);
        step_btn = 1; pulses = 0;
        repeat (12) begin step1(); pulses += int'(cpu_ce); end
        step_btn = 0;
        repeat (25) begin step1(); pulses += int'(cpu_ce); end
        chk("press12_pulses", pulses, 1);
`endif

        // sticky halt
        run_req = 1; div_sel = 5'd2;
        repeat (10) step1();
        halt_req = 1; step1(); halt_req = 0;
        chk("halt_mode", mode, 3);
        chk("halt_ce", cpu_ce, 0);
        pulses = 0; nonhalt = 0;
        for (int i = 0; i < 60; i++) begin
            step_btn = ((i / 15) % 2) == 1;
            step1();
            pulses += int'(cpu_ce);
            if (mode != 2'd3) nonhalt = 1;
        end
        chk("halt_pulses", pulses, 0);
        chk("halt_sticky", nonhalt, 0);
        step_btn = 0;
        rst = 1; step1(); rst = 0;
        chk("halt_rst_mode", mode, 0);
        run_req = 0;

        // reset on the cycle where the prescaler sits at its limit
        run_req = 1; div_sel = 5'd2; found = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            step1();
            if (cpu_ce) found = 1;
        end
        chk("t6_found_pulse", found, 1);
        repeat (3) step1();
        rst = 1; step1();
        chk("t6_ce", cpu_ce, 0);
        chk("t6_tick", tick_cnt, 0);
        chk("t6_mode", mode, 0);
        rst = 0; run_req = 0;
        step1();

        // random run against the behavioural model
        rst = 1; step1(); rst = 0;
        m_mode = 0; m_tick = 0; m_age = 0;
        bq = '{default: 1'b0};
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(299) == 0);
            if ($urandom_range(19) == 0) run_req = ~run_req;
            halt_req = ($urandom_range(399) == 0);
`ifndef STEP_DEBOUNCE_EN
            if ($urandom_range(5) == 0) step_btn = ~step_btn;
`endif
            if (!run_req && $urandom_range(7) == 0)
                div_sel = ($urandom_range(9) == 0) ? SEL_W'($urandom_range(31, 20))
                                                    : SEL_W'($urandom_range(4, 0));
            step1();

            // step edge: button seen high two edges back, low three edges back
            bq[3] = bq[2]; bq[2] = bq[1]; bq[1] = bq[0]; bq[0] = step_btn;
            se = bq[2] && !bq[3];
            per = 64'd1 << ((div_sel > 5'd22) ? 22 : int'(div_sel));
            m_ce = 0;
            if (rst) begin
                m_mode = 0; m_tick = 0; m_age = 0;
                bq = '{default: 1'b0};
            end else begin
                case (m_mode)
                    0: begin
                        if (halt_req)     m_mode = 3;
                        else if (run_req) begin m_mode = 1; m_age = 0; end
                        else if (se)      begin m_mode = 2; m_ce = 1; end
                    end
                    1: begin
                        if (halt_req)      m_mode = 3;
                        else if (!run_req) m_mode = 0;
                        else begin
                            m_age++;
                            if (m_age % per == 0) m_ce = 1;
                        end
                    end
                    2: m_mode = halt_req ? 3 : 0;
                    default: m_mode = 3;
                endcase
            end
            if (m_ce) m_tick = (m_tick + 1) % 65536;
            chk("rnd_ce", cpu_ce, m_ce);
            chk("rnd_mode", mode, m_mode);
            chk("rnd_tick", tick_cnt, m_tick);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
